// File: rtl/pc_next_if.sv
// Control/datapath bundle between decoder/ALU and the PC unit.
interface pc_next_if;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] jr_target;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        pcsrc;
  logic        err;
  logic [31:0] instret;

  modport master (
    output branch, zero, jump, jr, imm16, jidx, jr_target, stall, halt, resume,
    input  pc, pc_plus4, pc_valid, pcsrc, err, instret
  );

  modport slave (
    input  branch, zero, jump, jr, imm16, jidx, jr_target, stall, halt, resume,
    output pc, pc_plus4, pc_valid, pcsrc, err, instret
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS core.
// Optional retired-instruction counter enabled by defining PC_INSTRET_EN.
module pc_next_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  pc_next_if.slave   bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt, pc_plus4, br_tgt, j_tgt;
  logic        err_q, valid, pcsrc, go, misaligned;

  assign pc_plus4   = pc_q + 32'd4;
  assign br_tgt     = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign j_tgt      = {pc_plus4[31:28], bus.jidx, 2'b00};
  assign misaligned = bus.jr && (bus.jr_target[1:0] != 2'b00);
  // An instruction completes this edge only when running and not stalled
  assign go         = valid && !bus.stall;

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (!bus.stall) begin
          if (misaligned)    state_nxt = ERR;
          else if (bus.halt) state_nxt = HALT;
        end
      end
      HALT: if (bus.resume) state_nxt = RUN;
      ERR:  state_nxt = ERR;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    valid = (state == RUN);
    pcsrc = bus.branch && bus.zero && valid;
  end

  always_comb begin
    pc_nxt = pc_q;
    if (go && !misaligned) begin
      if (bus.jr)        pc_nxt = bus.jr_target;
      else if (bus.jump) pc_nxt = j_tgt;
      else if (pcsrc)    pc_nxt = br_tgt;
      else               pc_nxt = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (go && misaligned) err_q <= 1'b1;
    end
  end

`ifdef PC_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset)                  instret_q <= '0;
    else if (go && !misaligned) instret_q <= instret_q + 32'd1;
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.pc_valid = valid;
  assign bus.pcsrc    = pcsrc;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit against a behavioural PC model.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_next_if bus();

  pc_next_unit #(.RESET_VEC(32'h400)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference
  string       mode;
  logic [31:0] mpc;
  logic [31:0] minst;
  logic        merr;

  function automatic logic [31:0] exp_inst();
`ifdef PC_INSTRET_EN
    return minst;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic exp_valid();
    return mode == "RUN";
  endfunction

  task automatic model_step();
    logic [31:0] p4;
    if (reset) begin
      mode = "BOOT"; mpc = 32'h400; merr = 1'b0; minst = 0;
    end else if (mode == "BOOT") begin
      mode = "RUN";
    end else if (mode == "HALT") begin
      if (bus.resume) mode = "RUN";
    end else if (mode == "RUN" && !bus.stall) begin
      if (bus.jr && (bus.jr_target % 4 != 0)) begin
        merr = 1'b1;
        mode = "ERR";
      end else begin
        minst = minst + 1;
        p4 = mpc + 4;
        if (bus.jr)                     mpc = bus.jr_target;
        else if (bus.jump)              mpc = (p4 & 32'hF000_0000) | (32'(bus.jidx) * 4);
        else if (bus.branch && bus.zero) mpc = p4 + 32'(int'($signed(bus.imm16)) * 4);
        else                            mpc = p4;
        if (bus.halt) mode = "HALT";
      end
    end
  endtask

  task automatic idle();
    bus.branch = 0; bus.zero = 0; bus.jump = 0; bus.jr = 0;
    bus.imm16 = '0; bus.jidx = '0; bus.jr_target = '0;
    bus.stall = 0; bus.halt = 0; bus.resume = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    bus.jr = 1; bus.jr_target = v;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    reset = 1; idle();
    bus.branch = 1; bus.zero = 1;
    cycle();
    checks++; if (bus.pc !== 32'h400) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h400); end
    checks++; if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pc_valid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h expected 0", bus.instret); end
    checks++; if (bus.pcsrc !== 1'b0) begin errors++; $display("FAIL boot_pcsrc: got %b expected 0", bus.pcsrc); end
    reset = 0; idle();
    cycle();
    checks++; if (bus.pc !== 32'h400 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_run: got pc %h valid %b expected 400/1", bus.pc, bus.pc_valid); end
    cycle();
    checks++; if (bus.pc !== 32'h404) begin errors++; $display("FAIL first_inc: got %h expected 404", bus.pc); end
  endtask

  task automatic test_branch();
    set_pc(32'h100);
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL jr_set: got %h expected 100", bus.pc); end
    bus.branch = 1; bus.zero = 1; bus.imm16 = 16'hFFFF; #1;
    checks++; if (bus.pcsrc !== 1'b1) begin errors++; $display("FAIL pcsrc_taken: got %b expected 1", bus.pcsrc); end
    cycle();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL branch_back: got %h expected 100", bus.pc); end
    bus.zero = 0; #1;
    checks++; if (bus.pcsrc !== 1'b0) begin errors++; $display("FAIL pcsrc_not: got %b expected 0", bus.pcsrc); end
    cycle();
    checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL branch_not: got %h expected 104", bus.pc); end
    idle();
  endtask

  task automatic test_jump();
    set_pc(32'h3000_0010);
    bus.jump = 1; bus.jidx = 26'h10;
    cycle();
    checks++; if (bus.pc !== 32'h3000_0040) begin errors++; $display("FAIL jump: got %h expected 30000040", bus.pc); end
    bus.jr = 1; bus.jr_target = 32'h500; bus.branch = 1; bus.zero = 1;
    cycle();
    checks++; if (bus.pc !== 32'h500) begin errors++; $display("FAIL jr_priority: got %h expected 500", bus.pc); end
    idle();
  endtask

  task automatic test_stall();
    set_pc(32'h800);
    bus.stall = 1; bus.branch = 1; bus.zero = 1; bus.imm16 = 16'h4; bus.halt = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.pcsrc !== 1'b1) begin errors++; $display("FAIL stall_pcsrc: got %b expected 1", bus.pcsrc); end
      cycle();
      checks++; if (bus.pc !== 32'h800 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got pc %h valid %b expected 800/1", bus.pc, bus.pc_valid); end
      checks++; if (bus.instret !== exp_inst()) begin errors++; $display("FAIL stall_instret: got %h expected %h", bus.instret, exp_inst()); end
    end
    bus.stall = 0; bus.halt = 0;
    cycle();
    checks++; if (bus.pc !== 32'h814) begin errors++; $display("FAIL stall_release: got %h expected 814", bus.pc); end
    idle();
  endtask

  task automatic test_halt();
    set_pc(32'h200);
    bus.halt = 1;
    cycle();
    idle();
    checks++; if (bus.pc !== 32'h204 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: got pc %h valid %b expected 204/0", bus.pc, bus.pc_valid); end
    bus.jump = 1; bus.jidx = 26'h3; bus.branch = 1; bus.zero = 1; #1;
    checks++; if (bus.pcsrc !== 1'b0) begin errors++; $display("FAIL halt_pcsrc: got %b expected 0", bus.pcsrc); end
    cycle();
    checks++; if (bus.pc !== 32'h204 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL halt_ignore: got pc %h valid %b expected 204/0", bus.pc, bus.pc_valid); end
    idle(); bus.resume = 1;
    cycle();
    idle();
    checks++; if (bus.pc !== 32'h204 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL resume: got pc %h valid %b expected 204/1", bus.pc, bus.pc_valid); end
    cycle();
    checks++; if (bus.pc !== 32'h208) begin errors++; $display("FAIL resume_inc: got %h expected 208", bus.pc); end
    bus.jump = 1; bus.jidx = 26'h100; bus.halt = 1;
    cycle();
    idle(); bus.resume = 1;
    checks++; if (bus.pc !== 32'h400 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL halt_jump: got pc %h valid %b expected 400/0", bus.pc, bus.pc_valid); end
    cycle();
    idle();
    cycle();
    checks++; if (bus.pc !== 32'h404) begin errors++; $display("FAIL halt_jump_resume: got %h expected 404", bus.pc); end
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL plus4_wrap: got %h expected 0", bus.pc_plus4); end
    cycle();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 0", bus.pc); end
    bus.branch = 1; bus.zero = 1; bus.imm16 = 16'hFFFE;
    cycle();
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_wrap: got %h expected fffffffc", bus.pc); end
    idle();
  endtask

  task automatic test_err();
    set_pc(32'h300);
    bus.jr = 1; bus.jr_target = 32'h102;
    cycle();
    idle();
    checks++; if (bus.err !== 1'b1 || bus.pc_valid !== 1'b0 || bus.pc !== 32'h300) begin errors++; $display("FAIL err_enter: got err %b valid %b pc %h expected 1/0/300", bus.err, bus.pc_valid, bus.pc); end
    bus.resume = 1;
    cycle();
    checks++; if (bus.err !== 1'b1 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL err_sticky: got err %b valid %b expected 1/0", bus.err, bus.pc_valid); end
    idle(); reset = 1;
    cycle();
    reset = 0;
    checks++; if (bus.err !== 1'b0 || bus.pc !== 32'h400 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL err_reset: got err %b pc %h valid %b expected 0/400/0", bus.err, bus.pc, bus.pc_valid); end
    cycle();
    checks++; if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL err_reboot: got %b expected 1", bus.pc_valid); end
  endtask

  task automatic test_instret();
    idle(); reset = 1;
    cycle();
    reset = 0;
    cycle();
    for (int i = 0; i < 10; i++) cycle();
`ifdef PC_INSTRET_EN
    checks++; if (bus.instret !== 32'd10) begin errors++; $display("FAIL instret10: got %0d expected 10", bus.instret); end
`else
    checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL instret_tied: got %0d expected 0", bus.instret); end
`endif
    checks++; if (bus.pc !== 32'h428) begin errors++; $display("FAIL instret_pc: got %h expected 428", bus.pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = (mode == "ERR") ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      bus.branch    = 1'($urandom_range(0, 1));
      bus.zero      = 1'($urandom_range(0, 1));
      bus.jump      = ($urandom_range(0, 7) == 0);
      bus.jr        = ($urandom_range(0, 9) == 0);
      bus.jr_target = 32'($urandom);
      if ($urandom_range(0, 7) != 0) bus.jr_target[1:0] = 2'b00;
      bus.imm16     = 16'($urandom);
      bus.jidx      = 26'($urandom);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.halt      = ($urandom_range(0, 19) == 0);
      bus.resume    = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (bus.pcsrc !== (bus.branch & bus.zero & exp_valid())) begin errors++; $display("FAIL rnd_pcsrc[%0d]: got %b expected %b", i, bus.pcsrc, bus.branch & bus.zero & exp_valid()); end
      checks++; if (bus.pc_plus4 !== mpc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", i, bus.pc_plus4, mpc + 32'd4); end
      cycle();
      checks++; if (bus.pc !== mpc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, bus.pc, mpc); end
      checks++; if (bus.pc_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.pc_valid, exp_valid()); end
      checks++; if (bus.err !== merr) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, bus.err, merr); end
      checks++; if (bus.instret !== exp_inst()) begin errors++; $display("FAIL rnd_instret[%0d]: got %h expected %h", i, bus.instret, exp_inst()); end
    end
    reset = 0; idle();
  endtask

  initial begin
    mode = "BOOT"; mpc = 32'h400; merr = 1'b0; minst = 0;
    reset = 1; idle();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_wrap();
    test_err();
    test_instret();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
